// File: rtl/board_lock_sequencer_pkg.sv
// Shared constants, types and state encoding for the board lock sequencer.
package board_lock_sequencer_pkg;

   localparam int ROWS    = 80;
   localparam int COLS    = 40;
   localparam int PIX_W   = 4;
   localparam int SPR_MAX = 16;

   typedef logic [PIX_W-1:0] pix_t;
   typedef logic [6:0]       row_t;
   typedef logic [5:0]       col_t;

   typedef enum logic [2:0] {
      CLEAR,
      IDLE,
      WRITE,
      SCAN,
      SHIFT,
      DONE
   } state_t;

endpackage

// File: rtl/board_row_walker.sv
// Walks columns 0..COLS-1 of one board row through the shared read port,
// keeping at most one read in flight and issuing only when granted.
module board_row_walker
   import board_lock_sequencer_pkg::*;
(
   input  logic Clk,
   input  logic Reset,
   input  logic start,
   input  logic rd_gnt,
   output logic re,
   output col_t rcol,
   output logic resp_valid,
   output col_t resp_col,
   output logic resp_last
);

   logic issuing;
   col_t issue_col;

   assign re        = issuing & rd_gnt;
   assign rcol      = issue_col;
   assign resp_last = resp_valid && (resp_col == col_t'(COLS - 1));

   // Responses are tracked regardless of later grant loss: data always lands one cycle after issue.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         issuing    <= 1'b0;
         issue_col  <= '0;
         resp_valid <= 1'b0;
         resp_col   <= '0;
      end else begin
         resp_valid <= re;
         resp_col   <= issue_col;
         if (start) begin
            issuing   <= 1'b1;
            issue_col <= '0;
         end else if (re) begin
            issue_col <= issue_col + 6'd1;
            if (issue_col == col_t'(COLS - 1)) begin
               issuing <= 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/board_lock_sequencer.sv
// Sole writer of the playfield RAM: clears it, stamps locked sprites, and
// (with BOARD_ROW_CLEAR_EN defined) scans for and collapses full rows.
module board_lock_sequencer
   import board_lock_sequencer_pkg::*;
(
   input  logic             Clk,
   input  logic             Reset,
   input  logic             lock_req,
   input  logic [5:0]       lock_x,
   input  logic [6:0]       lock_y,
   input  logic [4:0]       spr_w,
   input  logic [4:0]       spr_h,
   output logic [3:0]       spr_row,
   output logic [3:0]       spr_col,
   input  logic [PIX_W-1:0] spr_pix,
   output logic             brd_we,
   output logic [6:0]       brd_wrow,
   output logic [5:0]       brd_wcol,
   output logic [PIX_W-1:0] brd_wdata,
   input  logic             rd_gnt,
   output logic             brd_re,
   output logic [6:0]       brd_rrow,
   output logic [5:0]       brd_rcol,
   input  logic [PIX_W-1:0] brd_rdata,
   output logic             busy,
   output logic             lock_done,
   output logic [4:0]       rows_cleared
);

   state_t     state, state_nxt;
   row_t       clr_row, cap_y, cur_row, dst_row;
   col_t       clr_col, cap_x, zcol;
   logic [4:0] cap_w, cap_h;
   logic [3:0] r_idx, c_idx;
   logic       zero_seen, zfill;
   logic       walk_start, walk_re, walk_resp, walk_last;
   col_t       walk_rcol, walk_resp_col;
   logic [7:0] tgt_row, tgt_col;
   logic       tgt_in, row_last_cell, cell_last, row_full;

   // Sprite targets are formed at 8 bits so cells hanging off the board compare as outside, not wrap.
   assign tgt_row       = 8'(cap_y) + 8'(r_idx);
   assign tgt_col       = 8'(cap_x) + 8'(c_idx);
   assign tgt_in        = (tgt_row < 8'(ROWS)) && (tgt_col < 8'(COLS));
   assign row_last_cell = (5'(c_idx) == cap_w - 5'd1);
   assign cell_last     = row_last_cell && (5'(r_idx) == cap_h - 5'd1);
   assign row_full      = !zero_seen && (brd_rdata != '0);
   assign brd_rcol      = walk_rcol;

   board_row_walker u_walker (
      .Clk        (Clk),
      .Reset      (Reset),
      .start      (walk_start),
      .rd_gnt     (rd_gnt),
      .re         (walk_re),
      .rcol       (walk_rcol),
      .resp_valid (walk_resp),
      .resp_col   (walk_resp_col),
      .resp_last  (walk_last)
   );

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= CLEAR;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      walk_start = 1'b0;
      busy       = 1'b1;
      lock_done  = 1'b0;
      spr_row    = '0;
      spr_col    = '0;
      brd_we     = 1'b0;
      brd_wrow   = '0;
      brd_wcol   = '0;
      brd_wdata  = '0;
      brd_rrow   = '0;
      brd_re     = walk_re & ~Reset;
      case (state)
         CLEAR: begin
            brd_we   = 1'b1;
            brd_wrow = clr_row;
            brd_wcol = clr_col;
            if (clr_row == row_t'(ROWS - 1) && clr_col == col_t'(COLS - 1)) begin
               state_nxt = IDLE;
            end
         end
         IDLE: begin
            busy = 1'b0;
            if (lock_req) begin
               state_nxt = WRITE;
            end
         end
         WRITE: begin
            spr_row   = r_idx;
            spr_col   = c_idx;
            brd_we    = tgt_in && (spr_pix != '0);
            brd_wrow  = tgt_row[6:0];
            brd_wcol  = tgt_col[5:0];
            brd_wdata = spr_pix;
            if (cell_last) begin
`ifdef BOARD_ROW_CLEAR_EN
               state_nxt  = SCAN;
               walk_start = 1'b1;
`else
               state_nxt  = DONE;
`endif
            end
         end
         SCAN: begin
            brd_rrow = cur_row;
            if (walk_last) begin
               if (row_full) begin
                  state_nxt  = SHIFT;
                  walk_start = (cur_row != '0);
               end else if (cur_row != '0) begin
                  walk_start = 1'b1;
               end else begin
                  state_nxt = DONE;
               end
            end
         end
         SHIFT: begin
            brd_rrow = dst_row - 7'd1;
            if (zfill) begin
               brd_we   = 1'b1;
               brd_wcol = zcol;
               if (zcol == col_t'(COLS - 1)) begin
                  state_nxt  = SCAN;
                  walk_start = 1'b1;
               end
            end else if (walk_resp) begin
               brd_we    = 1'b1;
               brd_wrow  = dst_row;
               brd_wcol  = walk_resp_col;
               brd_wdata = brd_rdata;
               if (walk_last && dst_row != 7'd1) begin
                  walk_start = 1'b1;
               end
            end
         end
         DONE: begin
            lock_done = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = CLEAR;
      endcase
      // A reset cycle must not let the interrupted sequence touch the board.
      if (Reset) begin
         brd_we    = 1'b0;
         lock_done = 1'b0;
         busy      = 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         clr_row      <= '0;
         clr_col      <= '0;
         cap_x        <= '0;
         cap_y        <= '0;
         cap_w        <= '0;
         cap_h        <= '0;
         r_idx        <= '0;
         c_idx        <= '0;
         cur_row      <= '0;
         dst_row      <= '0;
         zero_seen    <= 1'b0;
         zfill        <= 1'b0;
         zcol         <= '0;
         rows_cleared <= '0;
      end else begin
         case (state)
            CLEAR: begin
               if (clr_col == col_t'(COLS - 1)) begin
                  clr_col <= '0;
                  clr_row <= clr_row + 7'd1;
               end else begin
                  clr_col <= clr_col + 6'd1;
               end
            end
            IDLE: begin
               if (lock_req) begin
                  cap_x        <= lock_x;
                  cap_y        <= lock_y;
                  cap_w        <= spr_w;
                  cap_h        <= spr_h;
                  r_idx        <= '0;
                  c_idx        <= '0;
                  rows_cleared <= '0;
               end
            end
            WRITE: begin
               if (row_last_cell) begin
                  c_idx <= '0;
                  r_idx <= r_idx + 4'd1;
               end else begin
                  c_idx <= c_idx + 4'd1;
               end
               if (cell_last) begin
                  cur_row   <= row_t'(ROWS - 1);
                  zero_seen <= 1'b0;
               end
            end
            SCAN: begin
               if (walk_resp && brd_rdata == '0) begin
                  zero_seen <= 1'b1;
               end
               if (walk_last) begin
                  zero_seen <= 1'b0;
                  if (row_full) begin
                     dst_row <= cur_row;
                     zfill   <= (cur_row == '0);
                     zcol    <= '0;
                  end else if (cur_row != '0) begin
                     cur_row <= cur_row - 7'd1;
                  end
               end
            end
            SHIFT: begin
               if (zfill) begin
                  zcol <= zcol + 6'd1;
                  if (zcol == col_t'(COLS - 1)) begin
                     zfill     <= 1'b0;
                     zero_seen <= 1'b0;
                     if (rows_cleared != 5'd31) begin
                        rows_cleared <= rows_cleared + 5'd1;
                     end
                  end
               end else if (walk_last) begin
                  if (dst_row == 7'd1) begin
                     zfill <= 1'b1;
                     zcol  <= '0;
                  end else begin
                     dst_row <= dst_row - 7'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_board_lock_sequencer.sv
// Scoreboard bench: a board-level reference model queues the expected write
// stream and lock results; a monitor consumes them as the DUT produces them.
module tb_board_lock_sequencer;
   import board_lock_sequencer_pkg::*;

   typedef struct {
      int row;
      int col;
      int data;
   } wr_t;

`ifdef BOARD_ROW_CLEAR_EN
   localparam int EXTRA_AT = 150;
   localparam int ABORT_AT = 400;
`else
   localparam int EXTRA_AT = 10;
   localparam int ABORT_AT = 40;
`endif
   localparam int WAIT_LIMIT = 40000;

   logic             Clk;
   logic             Reset;
   logic             lock_req;
   logic [5:0]       lock_x;
   logic [6:0]       lock_y;
   logic [4:0]       spr_w;
   logic [4:0]       spr_h;
   logic [3:0]       spr_row;
   logic [3:0]       spr_col;
   logic [PIX_W-1:0] spr_pix;
   logic             brd_we;
   logic [6:0]       brd_wrow;
   logic [5:0]       brd_wcol;
   logic [PIX_W-1:0] brd_wdata;
   logic             rd_gnt;
   logic             brd_re;
   logic [6:0]       brd_rrow;
   logic [5:0]       brd_rcol;
   logic [PIX_W-1:0] brd_rdata;
   logic             busy;
   logic             lock_done;
   logic [4:0]       rows_cleared;

   logic [PIX_W-1:0] spr [16][16];
   logic [PIX_W-1:0] ram [ROWS][COLS];
   int               model [ROWS][COLS];
   wr_t              exp_q[$];
   int               done_q[$];
   int               errors = 0;
   int               checks = 0;
   int               gnt_mode = 0;
   int               gnt_phase = 0;

   board_lock_sequencer dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .lock_req     (lock_req),
      .lock_x       (lock_x),
      .lock_y       (lock_y),
      .spr_w        (spr_w),
      .spr_h        (spr_h),
      .spr_row      (spr_row),
      .spr_col      (spr_col),
      .spr_pix      (spr_pix),
      .brd_we       (brd_we),
      .brd_wrow     (brd_wrow),
      .brd_wcol     (brd_wcol),
      .brd_wdata    (brd_wdata),
      .rd_gnt       (rd_gnt),
      .brd_re       (brd_re),
      .brd_rrow     (brd_rrow),
      .brd_rcol     (brd_rcol),
      .brd_rdata    (brd_rdata),
      .busy         (busy),
      .lock_done    (lock_done),
      .rows_cleared (rows_cleared)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   assign spr_pix = spr[spr_row][spr_col];

   // Board RAM the DUT drives; read data appears one cycle after the read.
   always @(posedge Clk) begin
      if (brd_we && brd_wrow < 7'(ROWS) && brd_wcol < 6'(COLS))
         ram[brd_wrow][brd_wcol] <= brd_wdata;
      if (brd_re && brd_rrow < 7'(ROWS) && brd_rcol < 6'(COLS))
         brd_rdata <= ram[brd_rrow][brd_rcol];
   end

   initial begin
      rd_gnt = 1'b1;
      forever begin
         @(posedge Clk);
         #1;
         case (gnt_mode)
            0: rd_gnt = 1'b1;
            1: begin
               rd_gnt    = (gnt_phase == 0 || gnt_phase == 3);
               gnt_phase = (gnt_phase + 1) % 4;
            end
            default: rd_gnt = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   always @(negedge Clk) begin : monitor
      wr_t w;
      int  c;
      if (!Reset) begin
         if (brd_we) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("[TB] FAIL write_extra: got write (%0d,%0d)=%0d, expected no write",
                        brd_wrow, brd_wcol, brd_wdata);
            end else begin
               w = exp_q.pop_front();
               if (int'(brd_wrow) != w.row || int'(brd_wcol) != w.col || int'(brd_wdata) != w.data) begin
                  errors++;
                  $display("[TB] FAIL write: got (%0d,%0d)=%0d, expected (%0d,%0d)=%0d",
                           brd_wrow, brd_wcol, brd_wdata, w.row, w.col, w.data);
               end
            end
         end
         if (brd_re) begin
            checks++;
`ifdef BOARD_ROW_CLEAR_EN
            if (!rd_gnt) begin
               errors++;
               $display("[TB] FAIL read_without_gnt: got brd_re=1 with rd_gnt=0, expected no read");
            end
`else
            errors++;
            $display("[TB] FAIL read_disabled: got brd_re=1, expected 0 with row clear disabled");
`endif
         end
         if (lock_done) begin
            checks++;
            if (done_q.size() == 0) begin
               errors++;
               $display("[TB] FAIL done_extra: got lock_done=1, expected no completion");
            end else begin
               c = done_q.pop_front();
               if (int'(rows_cleared) != c) begin
                  errors++;
                  $display("[TB] FAIL rows_cleared_at_done: got %0d, expected %0d", rows_cleared, c);
               end
            end
         end
      end
   end

   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic void pushWrite(input int r, input int c, input int d);
      wr_t e;
      e.row  = r;
      e.col  = c;
      e.data = d;
      exp_q.push_back(e);
   endfunction

   task automatic checkBoard(input string name);
      int bad, fr, fc;
      bad = 0;
      fr  = 0;
      fc  = 0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            if (ram[r][c] !== 4'(model[r][c])) begin
               if (bad == 0) begin
                  fr = r;
                  fc = c;
               end
               bad++;
            end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("[TB] FAIL board_%s: got %0d differing cells, first (%0d,%0d)=%0h, expected %0d",
                  name, bad, fr, fc, ram[fr][fc], model[fr][fc]);
      end
   endtask

   task automatic resetDut();
      int n;
      @(posedge Clk);
      #1;
      Reset = 1'b1;
      exp_q.delete();
      done_q.delete();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) begin
            model[r][c] = 0;
            pushWrite(r, c, 0);
         end
      @(posedge Clk);
      #1;
      Reset = 1'b0;
      @(negedge Clk);
      checkOutput("reset_busy", int'(busy), 1);
      checkOutput("reset_lock_done", int'(lock_done), 0);
      checkOutput("reset_rows_cleared", int'(rows_cleared), 0);
      checkOutput("reset_brd_re", int'(brd_re), 0);
      n = 1;
      while (n < 5000) begin
         @(negedge Clk);
         if (!busy) break;
         n++;
      end
      checkOutput("clear_cycles", n, ROWS * COLS);
      checkOutput("clear_pending_writes", exp_q.size(), 0);
      checkBoard("after_clear");
   endtask

   task automatic fillSprite(input int mode, input int v);
      for (int i = 0; i < 16; i++)
         for (int j = 0; j < 16; j++)
            case (mode)
               0: spr[i][j] = 4'(v);
               1: spr[i][j] = 4'($urandom_range(1, 15));
               default: spr[i][j] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            endcase
   endtask

   task automatic prefillRow(input int r, input int v, input int from_col);
      for (int c = 0; c < COLS; c++) begin
         ram[r][c]   <= (c >= from_col) ? 4'(v) : 4'd0;
         model[r][c] = (c >= from_col) ? v : 0;
      end
   endtask

   // Stamp the sprite into the model, then collapse full rows bottom-up.
   task automatic applyStimulus(input int x, input int y, input int w, input int h, output int expc);
      int  p, r;
      bit  full;
      for (int i = 0; i < h; i++)
         for (int j = 0; j < w; j++) begin
            p = int'(spr[i][j]);
            if (p != 0 && y + i < ROWS && x + j < COLS) begin
               pushWrite(y + i, x + j, p);
               model[y + i][x + j] = p;
            end
         end
      expc = 0;
`ifdef BOARD_ROW_CLEAR_EN
      r = ROWS - 1;
      while (r >= 0) begin
         full = 1'b1;
         for (int c = 0; c < COLS; c++)
            if (model[r][c] == 0) full = 1'b0;
         if (full) begin
            for (int d = r; d >= 1; d--)
               for (int c = 0; c < COLS; c++) begin
                  pushWrite(d, c, model[d - 1][c]);
                  model[d][c] = model[d - 1][c];
               end
            for (int c = 0; c < COLS; c++) begin
               pushWrite(0, c, 0);
               model[0][c] = 0;
            end
            if (expc < 31) expc++;
         end else begin
            r--;
         end
      end
`else
      r    = 0;
      full = 1'b0;
`endif
      done_q.push_back(expc);
      @(posedge Clk);
      #1;
      lock_x   = 6'(x);
      lock_y   = 7'(y);
      spr_w    = 5'(w);
      spr_h    = 5'(h);
      lock_req = 1'b1;
      @(posedge Clk);
      #1;
      lock_req = 1'b0;
   endtask

   task automatic waitDone(input int extra_at, input int abort_at, output int lat, output bit aborted);
      int n;
      bit stop;
      n       = 0;
      stop    = 1'b0;
      lat     = 0;
      aborted = 1'b0;
      while (!stop && n < WAIT_LIMIT) begin
         @(negedge Clk);
         n++;
         lock_req = 1'b0;
         if (lock_done) begin
            lat  = n;
            stop = 1'b1;
         end else if (n == abort_at) begin
            aborted = 1'b1;
            stop    = 1'b1;
         end else if (n == extra_at) begin
            lock_x   = 6'($urandom);
            lock_y   = 7'($urandom);
            spr_w    = 5'($urandom_range(1, 16));
            spr_h    = 5'($urandom_range(1, 16));
            lock_req = 1'b1;
         end
      end
      if (!stop) begin
         checks++;
         errors++;
         $display("[TB] FAIL lock_timeout: got no lock_done in %0d cycles, expected completion", WAIT_LIMIT);
      end
   endtask

   task automatic finishLock(input string name, input int expc);
      @(negedge Clk);
      checkOutput({name, "_done_pulse"}, int'(lock_done), 0);
      checkOutput({name, "_busy"}, int'(busy), 0);
      checkOutput({name, "_rows_cleared"}, int'(rows_cleared), expc);
      checkOutput({name, "_pending_writes"}, exp_q.size(), 0);
      checkOutput({name, "_pending_done"}, done_q.size(), 0);
      checkBoard(name);
   endtask

   initial begin
      int lat, expc, x, y, w, h;
      bit aborted;
      Reset    = 1'b1;
      lock_req = 1'b0;
      lock_x   = '0;
      lock_y   = '0;
      spr_w    = 5'd1;
      spr_h    = 5'd1;
      fillSprite(0, 0);
      resetDut();

      gnt_mode = 0;
      fillSprite(0, 5);
      applyStimulus(10, 20, 4, 16, expc);
      waitDone(0, 0, lat, aborted);
`ifndef BOARD_ROW_CLEAR_EN
      checkOutput("latency_4x16", lat, 65);
`endif
      finishLock("tall", expc);

      gnt_mode = 2;
      fillSprite(1, 0);
      applyStimulus(38, 78, 4, 4, expc);
      waitDone(0, 0, lat, aborted);
      finishLock("corner_clip", expc);

      gnt_mode = 1;
      prefillRow(78, 3, 0);
      prefillRow(79, 3, 0);
      fillSprite(0, 6);
      applyStimulus(16, 40, 8, 8, expc);
      waitDone(0, 0, lat, aborted);
      finishLock("o_piece", expc);

      gnt_mode = 2;
      for (int k = 0; k < 2; k++) begin
         fillSprite(2, 0);
         x = $urandom_range(0, 45);
         y = $urandom_range(0, 83);
         w = $urandom_range(3, 8);
         h = $urandom_range(3, 8);
         applyStimulus(x, y, w, h, expc);
         waitDone((k == 1) ? 3 : 0, 0, lat, aborted);
         finishLock("random", expc);
      end

      prefillRow(50, 9, 4);
      fillSprite(0, 2);
      applyStimulus(0, 50, 4, 1, expc);
      waitDone(0, 0, lat, aborted);
      finishLock("mid_row", expc);

      gnt_mode = 0;
      prefillRow(79, 7, 0);
      fillSprite(1, 0);
      applyStimulus(0, 0, 8, 8, expc);
      waitDone(EXTRA_AT, ABORT_AT, lat, aborted);
      checkOutput("abort_reached", int'(aborted), 1);
      resetDut();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/board_lock_sequencer.md
Name: board_lock_sequencer

Overview:
- Sequences all updates to the scaled playfield memory: 80 rows x 40 columns, 4-bit pixel codes.
- On a lock request it copies the settled piece's sprite into the board one cell per cycle. It then scans rows bottom-up and collapses full rows.
- It is the only writer of the board RAM. It shares the board read port with the display path through an external grant.
- It replaces the ad-hoc one-cycle bulk load. Its lock_done pulse is the piece-respawn trigger sent to the block mover.

Parameters:
- ROWS, 80, board rows (y)
- COLS, 40, board columns (x)
- PIX_W, 4, bits per pixel code; 0 means empty
- SPR_MAX, 16, maximum sprite height or width in cells

Ports:
- Clk  in  1  clock
- Reset  in  1  synchronous, active-high
- lock_req  in  1  one-cycle pulse: piece has touched down or collided
- lock_x  in  6  sprite top-left column (scaled)
- lock_y  in  7  sprite top-left row (scaled)
- spr_w  in  5  sprite width in cells, 1..SPR_MAX
- spr_h  in  5  sprite height in cells, 1..SPR_MAX
- spr_row  out  4  sprite cell row index
- spr_col  out  4  sprite cell column index
- spr_pix  in  PIX_W  sprite pixel at (spr_row, spr_col); combinational, same cycle
- brd_we  out  1  board write enable
- brd_wrow  out  7  board write row
- brd_wcol  out  6  board write column
- brd_wdata  out  PIX_W  board write data
- rd_gnt  in  1  read port granted to this block this cycle; display owns it otherwise
- brd_re  out  1  read issue; only asserted when rd_gnt=1
- brd_rrow  out  7  board read row
- brd_rcol  out  6  board read column
- brd_rdata  in  PIX_W  read data, valid exactly 1 cycle after brd_re
- busy  out  1  high in every state except IDLE
- lock_done  out  1  one-cycle pulse when the lock sequence completes
- rows_cleared  out  5  rows removed by the last lock; held until the next lock starts

Behaviour:
- Reset values:
  - all outputs 0, except busy=1
  - state enters CLEAR
  - rows_cleared=0
- Reset asserted mid-operation aborts any sequence immediately; no further writes of the old sequence occur.
- CLEAR:
  - writes 0 to every cell, row-major from (0,0), one cell per cycle.
  - takes ROWS*COLS = 3200 cycles, then moves to IDLE.
- IDLE:
  - busy=0.
  - lock_req captures lock_x, lock_y, spr_w, spr_h, clears rows_cleared, and moves to WRITE next cycle.
- lock_req while busy=1 is ignored and has no side effects.
- WRITE:
  - iterates r = 0..spr_h-1 (outer) and c = 0..spr_w-1 (inner), one cell per cycle; spr_h*spr_w cycles total.
  - brd_we=1 only when spr_pix != 0 and the target is inside the board: lock_y+r < ROWS and lock_x+c < COLS.
  - zero pixels are transparent; out-of-board cells are silently dropped.
  - target address is (lock_y+r, lock_x+c), computed at 8-bit width to avoid wrap.
- SCAN:
  - current row starts at ROWS-1.
  - issues reads for columns 0..COLS-1 of the current row, pipelined; a new read is issued only in cycles with rd_gnt=1.
  - returned data is always captured one cycle after its issue, even if rd_gnt has since dropped.
  - after all COLS responses return: if no zero was seen, the row is full, go to SHIFT. Otherwise decrement the row; after row 0, go to DONE.
- SHIFT (row r full):
  - for each destination row d = r down to 1, and each column: read (d-1, col), then write the returned data to (d, col) on the response cycle.
  - after that, row 0 is written with zeros.
  - rows_cleared increments, saturating at 31; return to SCAN on the same row r, which now holds new contents.
- Read stalls (rd_gnt=0) freeze issue only; writes tied to a pending response still happen. The 1-cycle latency guarantees at most 1 read is outstanding.
- DONE: lock_done=1 for one cycle, then IDLE.
- A write and a read to the same cell in one cycle cannot occur, by construction: SHIFT reads row d-1 and writes row d.

Optional Feature:
- BOARD_ROW_CLEAR_EN defined: SCAN and SHIFT behave as above.
- Undefined: WRITE goes directly to DONE; rows_cleared stays 0; brd_re stays 0 permanently.

Decomposition:
- Shared package holds:
  - ROWS, COLS, PIX_W, SPR_MAX constants
  - pix_t typedef (logic [PIX_W-1:0])
  - row_t, col_t typedefs
  - state enum {CLEAR, IDLE, WRITE, SCAN, SHIFT, DONE}
- One natural sub-module: board_row_walker, the column counter plus 1-deep read pipeline and stall logic, used by both SCAN and SHIFT.

Test Plan:
- Reset held 1 cycle: busy=1 for 3200 cycles with brd_we=1 and brd_wdata=0 at every address; then busy=0.
- lock_req with lock_x=10, lock_y=20, spr_w=4, spr_h=16, all pixels 5 -> 64 writes of 5 to rows 20..35, columns 10..13; lock_done pulses 65 cycles later (SCAN disabled).
- lock_x=38, spr_w=4 -> only columns 38 and 39 written; no write to columns 40 or 41.
- Bottom two rows pre-filled with 3, then an O sprite (8x8) locked elsewhere -> rows_cleared=2; rows 78 and 79 receive the old rows 76 and 77; row 0 becomes 0.
- rd_gnt toggling 1,0,0,1 during SCAN -> the final board image is identical to the rd_gnt=1 run; no read is issued while gnt=0.
- lock_req asserted during SHIFT -> ignored; Reset asserted mid-SHIFT -> board returns to all zeros after CLEAR.
